// File: rtl/actbuf_port_arbiter.sv
// Four-port arbiter in front of a single-ported activation buffer SRAM.
// Round-robin arbitration with bounded burst locking and a one-cycle read-return path.
module actbuf_port_arbiter #(
  parameter int addrWidth = 16,
  parameter int dataWidth = 32,
  parameter int maxBurst  = 4
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   csr_main_clear,
  input  logic [3:0]             req_valid,
  output logic [3:0]             req_ready,
  input  logic [4*addrWidth-1:0] req_addr,
  input  logic [4*dataWidth-1:0] req_wdata,
  output logic [3:0]             rsp_valid,
  output logic [dataWidth-1:0]   rsp_data,
  output logic                   sram_en,
  output logic                   sram_wen,
  output logic [addrWidth-1:0]   sram_addr,
  output logic [dataWidth-1:0]   sram_wdata,
  input  logic [dataWidth-1:0]   sram_rdata,
  output logic [1:0]             grant_id,
  output logic                   grant_valid,
  output logic                   busy
);

  typedef enum logic {ARB, LOCK} state_t;

  localparam logic [3:0] BURST_MAX = 4'(maxBurst);

  state_t     state;
  logic [1:0] rr_ptr;
  logic [1:0] owner;
  logic [3:0] burst_cnt;
  logic       rsp_pend;
  logic [1:0] rsp_id;
  logic       hs;
  logic       rsp_out;

  // Grant is held off during reset so nothing leaks out combinationally from req_valid.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    grant_valid = 1'b0;
    grant_id    = 2'd0;
    if (nrst) begin
      if (state == LOCK) begin
        grant_id    = owner;
        grant_valid = req_valid[owner];
      end else begin
        // Walk the offsets downward so the lowest offset from rr_ptr wins.
        for (int k = 3; k >= 0; k--) begin
          if (req_valid[rr_ptr + 2'(k)]) begin
            grant_id    = rr_ptr + 2'(k);
            grant_valid = 1'b1;
          end
        end
      end
    end
  end

  assign hs        = grant_valid && !csr_main_clear;
  assign req_ready = hs ? (4'b0001 << grant_id) : 4'b0000;

  assign sram_en    = hs;
  assign sram_wen   = hs && !grant_id[0];
  assign sram_addr  = hs ? req_addr[grant_id*addrWidth +: addrWidth] : '0;
  assign sram_wdata = hs ? req_wdata[grant_id*dataWidth +: dataWidth] : '0;

  // A soft clear in the return cycle suppresses the response as well as dropping it.
  assign rsp_out   = rsp_pend && !csr_main_clear;
  assign rsp_valid = rsp_out ? (4'b0001 << rsp_id) : 4'b0000;
  assign rsp_data  = rsp_out ? sram_rdata : '0;

  assign busy = nrst && ((|req_valid) || (state == LOCK) || rsp_pend);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state     <= ARB;
      rr_ptr    <= 2'd0;
      owner     <= 2'd0;
      burst_cnt <= 4'd0;
      rsp_pend  <= 1'b0;
      rsp_id    <= 2'd0;
    end else if (csr_main_clear) begin
      state     <= ARB;
      rr_ptr    <= 2'd0;
      owner     <= 2'd0;
      burst_cnt <= 4'd0;
      rsp_pend  <= 1'b0;
    end else begin
      rsp_pend <= hs && grant_id[0];
      rsp_id   <= grant_id;
      case (state)
        ARB: begin
          if (hs) begin
            if (BURST_MAX > 4'd1) begin
              state     <= LOCK;
              owner     <= grant_id;
              burst_cnt <= 4'd1;
            end else begin
              rr_ptr <= grant_id + 2'd1;
            end
          end
        end
        LOCK: begin
          // Leave on the burst limit or as soon as the owner stops requesting.
          if (hs && (burst_cnt + 4'd1 != BURST_MAX)) begin
            burst_cnt <= burst_cnt + 4'd1;
          end else begin
            state     <= ARB;
            rr_ptr    <= owner + 2'd1;
            burst_cnt <= 4'd0;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule
